// File: rtl/fwd_pkg.sv
// Shared source-select encodings and immediate sign-extension helper for the operand stage.
package fwd_pkg;

    localparam logic [1:0] SRC_RF    = 2'd0;
    localparam logic [1:0] SRC_IMM12 = 2'd1;
    localparam logic [1:0] SRC_NPC   = 2'd2;
    localparam logic [1:0] SRC_IMMW  = 2'd3;

    // Replicates bit msb of imm into every higher bit; callers size-cast the result to DW.
    function automatic logic [63:0] sext(input logic [63:0] imm, input logic [5:0] msb);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i > int'(msb)) ? imm[msb] : imm[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_port.sv
// One source port: bypass priority encoder, stall-aware operand flop with held flag, source mux.
module fwd_port
    import fwd_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned NBYP = 4,
    parameter int unsigned IMMW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [DW-1:0]      rf_rd,
    input  logic [NBYP*DW-1:0] byp_data,
    input  logic [NBYP-1:0]    byp_sel,
    input  logic [1:0]         src_sel,
    input  logic [IMMW-1:0]    imm,
    input  logic [DW-1:0]      pc,
    output logic [DW-1:0]      src,
    output logic [DW-1:0]      opnd,
    output logic               held
);

    logic [DW-1:0] opnd_q;
    logic [DW-1:0] fwd;
    logic          any;
    logic          held_q;
    logic [63:0]   imm_x;

    // Walk from the oldest source down so the youngest requesting source wins.
    always_comb begin
        fwd = '0;
        any = |byp_sel;
        for (int b = NBYP - 1; b >= 0; b--) begin
            if (byp_sel[b]) begin
                fwd = byp_data[b*DW +: DW];
            end
        end
    end

    assign opnd = any ? fwd : opnd_q;
    assign held = held_q;

    // A stall with an active bypass captures it so a producer retiring mid-stall is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_q <= '0;
            held_q <= 1'b0;
        end else if (flush) begin
            opnd_q <= '0;
            held_q <= 1'b0;
        end else if (!stall) begin
            opnd_q <= rf_rd;
            held_q <= 1'b0;
        end else if (any) begin
            opnd_q <= fwd;
            held_q <= 1'b1;
        end
    end

    assign imm_x = 64'(imm);

    always_comb begin
        src = opnd;
        unique case (src_sel)
            SRC_RF:    src = opnd;
            SRC_IMM12: src = DW'(sext(imm_x, 6'd11));
            SRC_NPC:   src = pc;
            SRC_IMMW:  src = DW'(sext(imm_x, 6'(IMMW - 1)));
            default:   src = opnd;
        endcase
    end

endmodule

// File: rtl/operand_fwd_unit.sv
// ID/EX operand stage: per-port bypass/operand logic plus the port-0 store-data pipeline flop.
module operand_fwd_unit
    import fwd_pkg::*;
#(
    parameter int unsigned DW    = 32,
    parameter int unsigned NPORT = 2,
    parameter int unsigned NBYP  = 4,
    parameter int unsigned IMMW  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_ID_EX,
    input  logic                  stall_EX_DM,
    input  logic                  flush_ID_EX,
    input  logic [NPORT*DW-1:0]   rf_rd,
    input  logic [NBYP*DW-1:0]    byp_data,
    input  logic [NPORT*NBYP-1:0] byp_sel,
    input  logic [NPORT*2-1:0]    src_sel,
    input  logic [IMMW-1:0]       imm_ID_EX,
    input  logic [DW-1:0]         pc_ID_EX,
    output logic [NPORT*DW-1:0]   src,
    output logic [DW-1:0]         p0_EX_DM,
    output logic [NPORT-1:0]      fwd_held
);

    logic [NPORT*DW-1:0] opnd_bus;
    logic [DW-1:0]       p0_q;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        fwd_port #(
            .DW   (DW),
            .NBYP (NBYP),
            .IMMW (IMMW)
        ) u_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .stall    (stall_ID_EX),
            .flush    (flush_ID_EX),
            .rf_rd    (rf_rd[p*DW +: DW]),
            .byp_data (byp_data),
            .byp_sel  (byp_sel[p*NBYP +: NBYP]),
            .src_sel  (src_sel[p*2 +: 2]),
            .imm      (imm_ID_EX),
            .pc       (pc_ID_EX),
            .src      (src[p*DW +: DW]),
            .opnd     (opnd_bus[p*DW +: DW]),
            .held     (fwd_held[p])
        );
    end

    // Store data takes the forwarded operand, not the muxed source bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_q <= '0;
        end else if (!stall_EX_DM) begin
            p0_q <= opnd_bus[DW-1:0];
        end
    end

    assign p0_EX_DM = p0_q;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: comb vector table plus stall, flush, store and reset sequences.
module tb_operand_fwd_unit;

    logic        clk;
    logic        rst_n;
    logic        stall_ID_EX;
    logic        stall_EX_DM;
    logic        flush_ID_EX;
    logic [63:0] rf_rd;
    logic [127:0] byp_data;
    logic [7:0]  byp_sel;
    logic [3:0]  src_sel;
    logic [15:0] imm_ID_EX;
    logic [31:0] pc_ID_EX;
    logic [63:0] src;
    logic [31:0] p0_EX_DM;
    logic [1:0]  fwd_held;

    int n_chk;
    int n_fail;

    operand_fwd_unit #(
        .DW    (32),
        .NPORT (2),
        .NBYP  (4),
        .IMMW  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_ID_EX (stall_ID_EX),
        .stall_EX_DM (stall_EX_DM),
        .flush_ID_EX (flush_ID_EX),
        .rf_rd       (rf_rd),
        .byp_data    (byp_data),
        .byp_sel     (byp_sel),
        .src_sel     (src_sel),
        .imm_ID_EX   (imm_ID_EX),
        .pc_ID_EX    (pc_ID_EX),
        .src         (src),
        .p0_EX_DM    (p0_EX_DM),
        .fwd_held    (fwd_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sel;
        logic [3:0]  ssel;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b1;
        stall_ID_EX = 1'b0;
        stall_EX_DM = 1'b0;
        flush_ID_EX = 1'b0;
        rf_rd = {32'h0000_000B, 32'h0000_000A};
        byp_data = {32'h33, 32'h22, 32'h11, 32'hD0};
        byp_sel = '0;
        src_sel = '0;
        imm_ID_EX = '0;
        pc_ID_EX = '0;

        // sel = {port1, port0}; ssel = {port1, port0}: 0 RF, 1 IMM12, 2 NPC, 3 IMMW
        vecs[0] = '{8'h0A, 4'h0, 16'h0000, 32'h0,   32'h11,       32'hB};
        vecs[1] = '{8'h80, 4'h0, 16'h0000, 32'h0,   32'hA,        32'h33};
        vecs[2] = '{8'h4F, 4'h0, 16'h0000, 32'h0,   32'hD0,       32'h22};
        vecs[3] = '{8'h00, 4'hD, 16'h0F80, 32'h0,   32'hFFFFFF80, 32'h00000F80};
        vecs[4] = '{8'h00, 4'h2, 16'h0000, 32'h104, 32'h104,      32'hB};
        vecs[5] = '{8'h00, 4'hD, 16'h8001, 32'h0,   32'h00000001, 32'hFFFF8001};
        vecs[6] = '{8'h00, 4'h9, 16'h0800, 32'h104, 32'hFFFFF800, 32'h104};
        vecs[7] = '{8'h1A, 4'h1, 16'h0F80, 32'h0,   32'hFFFFFF80, 32'hD0};

        // Asynchronous reset at a non-edge time
        #1 rst_n = 1'b0;
        #2;
        chk("reset_src0", src[31:0], 32'h0);
        chk("reset_src1", src[63:32], 32'h0);
        chk("reset_p0", p0_EX_DM, 32'h0);
        chk("reset_held", {30'h0, fwd_held}, 32'h0);
        #10 rst_n = 1'b1;

        step();
        step();
        for (int i = 0; i < 8; i++) begin
            byp_sel = vecs[i].sel;
            src_sel = vecs[i].ssel;
            imm_ID_EX = vecs[i].imm;
            pc_ID_EX = vecs[i].pc;
            #1;
            chk($sformatf("vec%0d_src0", i), src[31:0], vecs[i].e0);
            chk($sformatf("vec%0d_src1", i), src[63:32], vecs[i].e1);
            step();
        end
        byp_sel = '0;
        src_sel = '0;

        // Stall capture on port 1, then producer drops its request
        stall_ID_EX = 1'b1;
        byp_data[127:96] = 32'h0000_CAFE;
        byp_sel = 8'h80;
        #1 chk("cap_same_cycle", src[63:32], 32'hCAFE);
        step();
        byp_sel = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("cap_hold%0d_src1", i), src[63:32], 32'hCAFE);
            chk($sformatf("cap_hold%0d_held", i), {31'h0, fwd_held[1]}, 32'h1);
            chk($sformatf("cap_hold%0d_src0", i), src[31:0], 32'hA);
            step();
        end
        stall_ID_EX = 1'b0;
        rf_rd[63:32] = 32'h0000_5555;
        step();
        chk("release_src1", src[63:32], 32'h5555);
        chk("release_held", {30'h0, fwd_held}, 32'h0);

        // Capture on port 0, then flush during stall with an active bypass
        stall_ID_EX = 1'b1;
        byp_sel = 8'h01;
        step();
        byp_sel = '0;
        #1 chk("pre_flush_held", {30'h0, fwd_held}, 32'h1);
        chk("pre_flush_src0", src[31:0], 32'hD0);
        byp_sel = 8'h11;
        flush_ID_EX = 1'b1;
        step();
        flush_ID_EX = 1'b0;
        byp_sel = '0;
        #1 chk("flush_src0", src[31:0], 32'h0);
        chk("flush_src1", src[63:32], 32'h0);
        chk("flush_held", {30'h0, fwd_held}, 32'h0);

        // Store-data pipe holds across an EX/DM stall
        stall_ID_EX = 1'b0;
        rf_rd[31:0] = 32'h111;
        step();
        step();
        chk("store_first", p0_EX_DM, 32'h111);
        stall_EX_DM = 1'b1;
        rf_rd[31:0] = 32'h222;
        step();
        chk("store_hold0", p0_EX_DM, 32'h111);
        step();
        chk("store_hold1", p0_EX_DM, 32'h111);
        chk("store_opnd_moved", src[31:0], 32'h222);
        stall_EX_DM = 1'b0;
        step();
        chk("store_release", p0_EX_DM, 32'h222);

        // Reset in the middle of a stall with captured state
        stall_ID_EX = 1'b1;
        byp_sel = 8'h20;
        step();
        byp_sel = '0;
        #1 chk("mid_cap_held", {30'h0, fwd_held}, 32'h2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_src0", src[31:0], 32'h0);
        chk("mid_rst_src1", src[63:32], 32'h0);
        chk("mid_rst_p0", p0_EX_DM, 32'h0);
        chk("mid_rst_held", {30'h0, fwd_held}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
